// File: rtl/mips_16_imem_loader.sv
// mips_16_imem_loader: assembles a byte-stream program image into imem words and holds the core in reset until it verifies.
module mips_16_imem_loader #(
    parameter int ADDR_W  = 8,
    parameter bit CSUM_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);
    typedef enum logic [2:0] {LEN, LO, HI, CSUM, REL, RUN, ERR} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] n, addr;
    logic [7:0] sum, lo;
    logic acc, last;
    always_comb begin
        rx_ready = (state == LEN || state == LO || state == HI || state == CSUM) && !reload;
        acc = rx_valid && rx_ready;
        last = addr == n - ADDR_W'(1);
        state_nx = state;
        case (state)
            LEN:     state_nx = acc ? LO : LEN;
            LO:      state_nx = acc ? HI : LO;
            HI:      state_nx = !acc ? HI : !last ? LO : CSUM_EN ? CSUM : REL;
            CSUM:    state_nx = !acc ? CSUM : rx_data == sum ? REL : ERR;
            REL:     state_nx = RUN;
            default: state_nx = state;
        endcase
        if (reload) state_nx = LEN;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LEN;
        else state <= state_nx;
    end
    // N of zero truncates to 0, so n-1 wraps to the top address and the full space is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n <= '0;
            addr <= '0;
            sum <= '0;
            lo <= '0;
            imem_we <= 1'b0;
            imem_addr <= '0;
            imem_wdata <= '0;
            core_rst <= 1'b1;
            load_done <= 1'b0;
            load_err <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (reload) begin
                addr <= '0;
                sum <= '0;
                core_rst <= 1'b1;
                load_done <= 1'b0;
                load_err <= 1'b0;
            end else begin
                if (acc && state == LEN) begin
                    n <= ADDR_W'(rx_data);
                    addr <= '0;
                    sum <= '0;
                end
                if (acc && state == LO) begin
                    lo <= rx_data;
                    sum <= sum + rx_data;
                end
                if (acc && state == HI) begin
                    imem_we <= 1'b1;
                    imem_addr <= addr;
                    imem_wdata <= {rx_data, lo};
                    sum <= sum + rx_data;
                    if (!last) addr <= addr + ADDR_W'(1);
                end
                if (acc && state == CSUM && rx_data != sum) load_err <= 1'b1;
                if (state == REL) begin
                    core_rst <= 1'b0;
                    load_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mips_16_imem_loader.sv
// tb_mips_16_imem_loader: randomized scenarios checked against a stream-level model of the loader.
module tb_mips_16_imem_loader;
    logic clk = 0, rst = 0, rx_valid = 0, reload = 0;
    logic [7:0] rx_data = 0;
    logic rx_ready, imem_we, core_rst, load_done, load_err;
    logic [7:0] imem_addr;
    logic [15:0] imem_wdata;
    int total = 0, bad = 0;
    logic [23:0] got_w[$], exp_w[$];
    logic [7:0] stim[$];
    bit exp_ok;

    mips_16_imem_loader #(.ADDR_W(8), .CSUM_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (imem_we) got_w.push_back({imem_addr, imem_wdata});

    function automatic void model();
        int n = (stim[0] == 0) ? 256 : int'(stim[0]);
        logic [7:0] s = 0;
        exp_w.delete();
        for (int k = 0; k < n; k++) begin
            exp_w.push_back({8'(k), stim[2 + 2 * k], stim[1 + 2 * k]});
            s = s + stim[1 + 2 * k] + stim[2 + 2 * k];
        end
        exp_ok = stim[2 * n + 1] == s;
    endfunction

    function automatic bit writes_match();
        if (got_w.size() != exp_w.size()) return 0;
        foreach (exp_w[i]) if (got_w[i] !== exp_w[i]) return 0;
        return 1;
    endfunction

    function automatic void make_stream(int n, bit good);
        logic [7:0] s = 0, b;
        stim.delete();
        stim.push_back(8'(n));
        for (int k = 0; k < 2 * n; k++) begin
            b = 8'($urandom);
            stim.push_back(b);
            s = s + b;
        end
        stim.push_back(good ? s : s + 8'd1);
    endfunction

    task automatic send(input logic [7:0] b, input bit gaps);
        bit ok = 0;
        if (gaps) begin
            rx_valid = 0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rx_data = b;
        rx_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1 ok = rx_ready;
            @(negedge clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout byte=%02h rx_ready=%b required=1", b, rx_ready);
        end
    endtask

    task automatic load_stream(input bit gaps);
        foreach (stim[i]) send(stim[i], gaps);
        rx_valid = 0;
    endtask

    task automatic do_reload();
        reload = 1;
        @(negedge clk);
        reload = 0;
        got_w.delete();
    endtask

    task automatic check_outcome(input string name);
        repeat (3) @(negedge clk);
        total++;
        if (!writes_match()) begin
            bad++;
            $display("FAIL %s_writes got=%0d words required=%0d words", name, got_w.size(), exp_w.size());
        end
        total++;
        if ({load_done, load_err, core_rst} !== {exp_ok, !exp_ok, !exp_ok}) begin
            bad++;
            $display("FAIL %s_status done/err/core_rst=%b%b%b required=%b%b%b", name,
                     load_done, load_err, core_rst, exp_ok, !exp_ok, !exp_ok);
        end
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({core_rst, rx_ready, imem_we, load_done, load_err, imem_addr, imem_wdata} !== {5'b11000, 24'h0}) begin
            bad++;
            $display("FAIL reset_held cr/rdy/we/done/err=%b%b%b%b%b addr=%h data=%h required=11000 0 0",
                     core_rst, rx_ready, imem_we, load_done, load_err, imem_addr, imem_wdata);
        end
        rst = 1;
        @(negedge clk);
        total++;
        if ({core_rst, rx_ready, imem_we, load_done, load_err} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_release cr/rdy/we/done/err=%b%b%b%b%b required=11000",
                     core_rst, rx_ready, imem_we, load_done, load_err);
        end
    endtask

    task automatic test_nominal();
        stim = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
        model();
        got_w.delete();
        load_stream(0);
        total++;
        if (load_done !== 1'b0 || core_rst !== 1'b1) begin
            bad++;
            $display("FAIL nominal_early done=%b core_rst=%b required=0 1", load_done, core_rst);
        end
        @(negedge clk);
        total++;
        if (load_done !== 1'b1 || core_rst !== 1'b0) begin
            bad++;
            $display("FAIL nominal_release done=%b core_rst=%b required=1 0", load_done, core_rst);
        end
        total++;
        if (got_w.size() != 2 || got_w[0] !== 24'h001234 || got_w[1] !== 24'h015678) begin
            bad++;
            $display("FAIL nominal_words count=%0d required=2 (00:1234, 01:5678)", got_w.size());
        end
        check_outcome("nominal");
    endtask

    task automatic test_bad_csum();
        reload = 1;
        @(negedge clk);
        reload = 0;
        total++;
        if (core_rst !== 1'b1 || load_done !== 1'b0) begin
            bad++;
            $display("FAIL reload_from_run core_rst=%b done=%b required=1 0", core_rst, load_done);
        end
        got_w.delete();
        stim = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h15};
        model();
        load_stream(0);
        check_outcome("bad_csum");
        total++;
        if (rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL bad_csum_ready rx_ready=%b required=0", rx_ready);
        end
        do_reload();
        stim[5] = 8'h14;
        model();
        load_stream(0);
        check_outcome("bad_then_good");
    endtask

    task automatic test_gaps();
        for (int it = 0; it < 4; it++) begin
            do_reload();
            make_stream($urandom_range(1, 6), it != 2);
            model();
            load_stream(1);
            check_outcome("gaps");
        end
    endtask

    task automatic test_wrap();
        do_reload();
        stim.delete();
        stim.push_back(8'h00);
        for (int k = 0; k < 256; k++) begin
            stim.push_back(8'(k));
            stim.push_back(8'(k));
        end
        stim.push_back(8'h00);
        model();
        load_stream(0);
        check_outcome("wrap");
        total++;
        if (got_w.size() != 256 || got_w[255] !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL wrap_last count=%0d required=256 last=ff:ffff", got_w.size());
        end
    endtask

    task automatic test_reload_in_hi();
        do_reload();
        send(8'h03, 0);
        send(8'h99, 0);
        rx_data = 8'hAA;
        rx_valid = 1;
        reload = 1;
        #1;
        total++;
        if (rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL reload_hi_ready rx_ready=%b required=0", rx_ready);
        end
        @(negedge clk);
        reload = 0;
        rx_valid = 0;
        got_w.delete();
        stim = '{8'h01, 8'h11, 8'h22, 8'h33};
        model();
        load_stream(0);
        check_outcome("reload_hi");
    endtask

    task automatic test_rst_mid();
        do_reload();
        make_stream(4, 1);
        for (int i = 0; i < 5; i++) send(stim[i], 0);
        rx_valid = 0;
        #2 rst = 0;
        #1;
        total++;
        if ({core_rst, imem_we, load_done, load_err, imem_addr, imem_wdata} !== {4'b1000, 24'h0}) begin
            bad++;
            $display("FAIL rst_mid cr/we/done/err=%b%b%b%b addr=%h data=%h required=1000 0 0",
                     core_rst, imem_we, load_done, load_err, imem_addr, imem_wdata);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        got_w.delete();
        model();
        load_stream(1);
        check_outcome("after_rst");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_csum();
        test_gaps();
        test_wrap();
        test_reload_in_hi();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
